// File: rtl/mips_core_pkg.sv
// Shared types and constants for the data-cache port arbiter and its store buffer.
package mips_core_pkg;

  localparam int unsigned ROB_DEPTH_BITS       = 5;
  localparam int unsigned SB_DEPTH_DEFAULT     = 8;
  localparam int unsigned SB_DEPTH_BITS        = $clog2(SB_DEPTH_DEFAULT);
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  // Storage width of a buffered store; narrower configurations zero-extend into it.
  localparam int unsigned SB_ADDR_WIDTH = 32;
  localparam int unsigned SB_DATA_WIDTH = 32;

  typedef struct packed {
    logic                     valid;
    logic [SB_ADDR_WIDTH-1:0] addr;
    logic [SB_DATA_WIDTH-1:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // Increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular FIFO of committed stores. Entries stay valid until the cache accepts them,
// so the parallel address compare also covers the store currently on the cache port.
module store_buffer_fifo
  import mips_core_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SB_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic                  multi,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [DATA_WIDTH-1:0] next_data,
  input  logic [ADDR_WIDTH-1:0] cmp_addr,
  output logic                  cmp_hit
);

  localparam int unsigned IdxW = $clog2(SB_DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  sb_entry_t           mem_q [SB_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0]     count;
  logic [IdxW-1:0]     wr_idx, rd_idx, nx_idx;
  logic                push_en, pop_en;

  assign wr_idx = wr_ptr_q[IdxW-1:0];
  assign rd_idx = rd_ptr_q[IdxW-1:0];
  assign nx_idx = rd_idx + IdxW'(1);
  assign count  = wr_ptr_q - rd_ptr_q;

  // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
  assign full  = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) && (wr_idx == rd_idx);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign multi = (count > PtrW'(1));

  // A push into a full buffer is only safe when the head leaves in the same cycle.
  assign push_en = push && (!full || pop);
  assign pop_en  = pop && !empty;

  assign head_addr = ADDR_WIDTH'(mem_q[rd_idx].addr);
  assign head_data = DATA_WIDTH'(mem_q[rd_idx].data);
  assign next_addr = ADDR_WIDTH'(mem_q[nx_idx].addr);
  assign next_data = DATA_WIDTH'(mem_q[nx_idx].data);

  // Pointer and entry storage; a push overrides a pop of the same slot when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (pop_en) begin
        mem_q[rd_idx].valid <= 1'b0;
        rd_ptr_q            <= rd_ptr_q + PtrW'(1);
      end
      if (push_en) begin
        mem_q[wr_idx].valid <= 1'b1;
        mem_q[wr_idx].addr  <= SB_ADDR_WIDTH'(push_addr);
        mem_q[wr_idx].data  <= SB_DATA_WIDTH'(push_data);
        wr_ptr_q            <= wr_ptr_q + PtrW'(1);
      end
    end
  end

  // Full-address match against every live entry.
  always_comb begin
    cmp_hit = 1'b0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if (mem_q[i].valid && (mem_q[i].addr == SB_ADDR_WIDTH'(cmp_addr))) begin
        cmp_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the single d-cache request port between speculative loads and buffered
// committed stores. Optional perf counters are enabled by defining DCACHE_ARB_PERF_EN.
module dcache_port_arbiter
  import mips_core_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned TAG_BITS     = ROB_DEPTH_BITS,
  parameter int unsigned SB_DEPTH     = SB_DEPTH_DEFAULT,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [TAG_BITS-1:0]   ld_tag,
  output logic                  ld_grant,
  input  logic                  st_commit,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  output logic                  sb_full,
  output logic                  sb_empty,
  input  logic                  drain_req,
  output logic                  drain_done,
  input  logic                  cache_ready,
  output logic                  req_valid,
  output logic                  req_write,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_data,
  output logic [TAG_BITS-1:0]   req_tag
`ifdef DCACHE_ARB_PERF_EN
  ,
  output logic [31:0]           perf_ld_grants,
  output logic [31:0]           perf_st_grants,
  output logic [31:0]           perf_conflict_cycles
`endif
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  arb_state_t             state_q, state_d;
  logic                   req_valid_q, req_valid_d;
  logic                   req_write_q, req_write_d;
  logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]  req_data_q, req_data_d;
  logic [TAG_BITS-1:0]    req_tag_q, req_tag_d;
  logic [StarveW-1:0]     starve_q, starve_d;

  logic                   sb_multi, sb_hit;
  logic [ADDR_WIDTH-1:0]  sb_head_addr, sb_next_addr, st_cand_addr;
  logic [DATA_WIDTH-1:0]  sb_head_data, sb_next_data, st_cand_data;
  logic                   st_inflight, ld_inflight, st_accept, port_free;
  logic                   st_avail, ld_block, ld_ok, can_issue, st_win, ld_win;

  store_buffer_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SB_DEPTH   (SB_DEPTH)
  ) u_store_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (st_commit),
    .push_addr (st_addr),
    .push_data (st_data),
    .pop       (st_accept),
    .full      (sb_full),
    .empty     (sb_empty),
    .multi     (sb_multi),
    .head_addr (sb_head_addr),
    .head_data (sb_head_data),
    .next_addr (sb_next_addr),
    .next_data (sb_next_data),
    .cmp_addr  (ld_addr),
    .cmp_hit   (sb_hit)
  );

  assign st_inflight = req_valid_q && req_write_q;
  assign ld_inflight = req_valid_q && !req_write_q;
  assign st_accept   = st_inflight && cache_ready;
  assign port_free   = !req_valid_q || cache_ready;

  // The in-flight store is still the buffer head; when it leaves this cycle the
  // next candidate is the entry behind it.
  assign st_avail     = st_accept ? sb_multi : !sb_empty;
  assign st_cand_addr = st_accept ? sb_next_addr : sb_head_addr;
  assign st_cand_data = st_accept ? sb_next_data : sb_head_data;

  assign ld_block = sb_hit || (st_inflight && (req_addr_q == ld_addr));
  assign ld_ok    = ld_valid && !ld_block && !drain_req;
  // Nothing new is registered during a flush so a dropped load leaves the port idle.
  assign can_issue = port_free && !flush;
  assign st_win    = can_issue && st_avail &&
                     (sb_full || (starve_q >= StarveW'(STARVE_LIMIT)) || !ld_ok);
  assign ld_win    = can_issue && ld_ok && !st_win;

  assign ld_grant   = ld_win;
  assign drain_done = (state_q == DRAIN) && sb_empty && !st_inflight;

  assign req_valid = req_valid_q;
  assign req_write = req_write_q;
  assign req_addr  = req_addr_q;
  assign req_data  = req_data_q;
  assign req_tag   = req_tag_q;

  // Next request, starvation count and arbitration state.
  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_tag_d   = req_tag_q;
    starve_d    = starve_q;

    if (st_win) begin
      req_valid_d = 1'b1;
      req_write_d = 1'b1;
      req_addr_d  = st_cand_addr;
      req_data_d  = st_cand_data;
      req_tag_d   = '0;
    end else if (ld_win) begin
      req_valid_d = 1'b1;
      req_write_d = 1'b0;
      req_addr_d  = ld_addr;
      req_data_d  = '0;
      req_tag_d   = ld_tag;
    end else if (port_free || (flush && ld_inflight)) begin
      req_valid_d = 1'b0;
      req_write_d = 1'b0;
      req_addr_d  = '0;
      req_data_d  = '0;
      req_tag_d   = '0;
    end

    if (sb_empty || st_win) begin
      starve_d = '0;
    end else if (ld_win && (starve_q < StarveW'(STARVE_LIMIT))) begin
      starve_d = starve_q + StarveW'(1);
    end

    unique case (state_q)
      IDLE, BUSY: state_d = drain_req ? DRAIN : (req_valid_d ? BUSY : IDLE);
      DRAIN:      if (!drain_req) state_d = req_valid_d ? BUSY : IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Registered request port and arbitration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_tag_q   <= '0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_tag_q   <= req_tag_d;
      starve_q    <= starve_d;
    end
  end

`ifdef DCACHE_ARB_PERF_EN
  // Saturating event counters; untouched by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ld_grants       <= '0;
      perf_st_grants       <= '0;
      perf_conflict_cycles <= '0;
    end else begin
      if (ld_win)               perf_ld_grants       <= sat_inc32(perf_ld_grants);
      if (st_win)               perf_st_grants       <= sat_inc32(perf_st_grants);
      if (ld_valid && ld_block) perf_conflict_cycles <= sat_inc32(perf_conflict_cycles);
    end
  end
`endif

`ifndef SYNTHESIS
  // A commit into a full buffer with no same-cycle pop would lose the store.
  assert property (@(posedge clk) disable iff (!rst_n) !(st_commit && sb_full && !st_accept));
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench: the driver advances a queue-based reference model each cycle and
// pushes expectations; a monitor pops and compares at the falling edge.
module tb_dcache_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 5;
  localparam int DEPTH = 8;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, ld_valid, ld_grant, st_commit, sb_full, sb_empty;
  logic [AW-1:0] ld_addr, st_addr, req_addr;
  logic [TW-1:0] ld_tag, req_tag;
  logic [DW-1:0] st_data, req_data;
  logic          drain_req, drain_done, cache_ready, req_valid, req_write;
`ifdef DCACHE_ARB_PERF_EN
  logic [31:0]   perf_ld_grants, perf_st_grants, perf_conflict_cycles;
`endif

  always #5 clk = ~clk;

  dcache_port_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .TAG_BITS     (TW),
    .SB_DEPTH     (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_tag      (ld_tag),
    .ld_grant    (ld_grant),
    .st_commit   (st_commit),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .sb_full     (sb_full),
    .sb_empty    (sb_empty),
    .drain_req   (drain_req),
    .drain_done  (drain_done),
    .cache_ready (cache_ready),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_tag     (req_tag)
`ifdef DCACHE_ARB_PERF_EN
    ,
    .perf_ld_grants       (perf_ld_grants),
    .perf_st_grants       (perf_st_grants),
    .perf_conflict_cycles (perf_conflict_cycles)
`endif
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } st_t;
  typedef struct { logic write; logic [AW-1:0] addr; logic [DW-1:0] data; logic [TW-1:0] tag; } txn_t;
  typedef struct { logic ld_grant, sb_full, sb_empty, drain_done, req_valid; } cyc_t;

  st_t  sbq[$];    // stores held in the buffer, oldest first (includes the one on the port)
  txn_t txn_q[$];  // requests issued and not yet accepted
  cyc_t cyc_q[$];  // per-cycle expected status

  logic m_valid, m_write, m_drain;
  int   m_starve;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model across the clock edge.
  task automatic step(input logic f, input logic lv, input logic [AW-1:0] la,
                      input logic [TW-1:0] lt, input logic sc, input logic [AW-1:0] sa,
                      input logic [DW-1:0] sd, input logic dr, input logic cr);
    cyc_t c;
    txn_t t;
    logic blk, st_acc, free, lok, sw, lw;
    int   avail, pre;
    flush = f; ld_valid = lv; ld_addr = la; ld_tag = lt;
    st_commit = sc; st_addr = sa; st_data = sd; drain_req = dr; cache_ready = cr;

    pre = sbq.size();
    blk = 1'b0;
    foreach (sbq[i]) if (sbq[i].addr == la) blk = 1'b1;
    st_acc = m_valid && m_write && cr;
    free   = !m_valid || cr;
    avail  = pre - (st_acc ? 1 : 0);
    lok    = lv && !blk && !dr;
    sw     = free && !f && (avail > 0) && (pre == DEPTH || m_starve >= LIMIT || !lok);
    lw     = free && !f && lok && !sw;

    c.ld_grant   = lw;
    c.sb_full    = (pre == DEPTH);
    c.sb_empty   = (pre == 0);
    c.drain_done = m_drain && (pre == 0) && !(m_valid && m_write);
    c.req_valid  = m_valid;
    cyc_q.push_back(c);

    if (pre == 0 || sw) m_starve = 0;
    else if (lw && m_starve < LIMIT) m_starve++;

    if (sw) begin
      t.write = 1'b1; t.addr = sbq[st_acc ? 1 : 0].addr; t.data = sbq[st_acc ? 1 : 0].data;
      t.tag = '0;
      txn_q.push_back(t);
      m_valid = 1'b1; m_write = 1'b1;
    end else if (lw) begin
      t.write = 1'b0; t.addr = la; t.data = '0; t.tag = lt;
      txn_q.push_back(t);
      m_valid = 1'b1; m_write = 1'b0;
    end else if (free) begin
      m_valid = 1'b0;
    end else if (f && !m_write) begin
      m_valid = 1'b0;
      void'(txn_q.pop_back());
    end

    if (st_acc) void'(sbq.pop_front());
    if (sc && (pre < DEPTH || st_acc)) sbq.push_back('{addr: sa, data: sd});
    m_drain = dr;

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic cr);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0, 0, cr);
  endtask

  // Monitor: compares status every cycle and request contents at acceptance.
  initial begin
    cyc_t c;
    txn_t t;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        check("ld_grant", ld_grant, c.ld_grant);
        check("sb_full", sb_full, c.sb_full);
        check("sb_empty", sb_empty, c.sb_empty);
        check("drain_done", drain_done, c.drain_done);
        check("req_valid", req_valid, c.req_valid);
        if (req_valid && cache_ready) begin
          check("txn_expected", txn_q.size() > 0, 1);
          if (txn_q.size() > 0) begin
            t = txn_q.pop_front();
            check("req_write", req_write, t.write);
            check("req_addr", req_addr, t.addr);
            check("req_data", req_data, t.data);
            check("req_tag", req_tag, t.tag);
          end
        end
      end
    end
  end

  initial begin
    logic          cr, sc, lv, dr_lvl;
    logic [AW-1:0] a;
    flush = 0; ld_valid = 0; ld_addr = '0; ld_tag = '0; st_commit = 0; st_addr = '0;
    st_data = '0; drain_req = 0; cache_ready = 0; rst_n = 0;
    m_valid = 0; m_write = 0; m_drain = 0; m_starve = 0;

    repeat (2) @(negedge clk);
    check("rst_req_valid", req_valid, 0);
    check("rst_req_write", req_write, 0);
    check("rst_req_addr", req_addr, 0);
    check("rst_ld_grant", ld_grant, 0);
    check("rst_sb_empty", sb_empty, 1);
    check("rst_sb_full", sb_full, 0);
    check("rst_drain_done", drain_done, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Single load: grant now, request on the port next cycle.
    step(0, 1, 32'h100, 5'd3, 0, '0, '0, 0, 1);
    idle(2, 1);

    // Load to a buffered store address waits for the store to be accepted.
    step(0, 0, '0, '0, 1, 32'h200, 32'hDEAD_0200, 0, 0);
    repeat (3) step(0, 1, 32'h200, 5'd5, 0, '0, '0, 0, 0);
    repeat (3) step(0, 1, 32'h200, 5'd5, 0, '0, '0, 0, 1);
    idle(2, 1);

    // Starvation bound: a waiting store gets through after LIMIT loads.
    step(0, 1, 32'h1000, 5'd1, 1, 32'h500, 32'h0000_0055, 0, 1);
    for (int i = 1; i < 8; i++) step(0, 1, 32'h1000 + 32'(4 * i), 5'(i), 0, '0, '0, 0, 1);
    idle(2, 1);

    // Fill the buffer while stalled, then commit and accept in the same cycle.
    for (int i = 0; i < DEPTH; i++)
      step(0, 0, '0, '0, 1, 32'h2000 + 32'(4 * i), 32'hA000 + 32'(i), 0, 0);
    repeat (2) step(0, 1, 32'h2000, 5'd7, 0, '0, '0, 0, 0);
    step(0, 0, '0, '0, 1, 32'h2100, 32'hA100, 0, 1);
    step(0, 0, '0, '0, 0, '0, '0, 0, 0);
    idle(12, 1);

    // Drain with loads pending: only stores issue, then drain_done.
    for (int i = 0; i < 3; i++)
      step(0, 0, '0, '0, 1, 32'h3000 + 32'(4 * i), 32'hB000 + 32'(i), 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 32'h4000 + 32'(4 * i), 5'(i), 0, '0, '0, 1, 1);
    step(0, 1, 32'h4100, 5'd2, 0, '0, '0, 0, 1);
    idle(2, 1);

    // Flush a stalled load; buffered stores still go out.
    step(0, 1, 32'h300, 5'd9, 1, 32'h3100, 32'h0000_00F1, 0, 0);
    step(0, 0, '0, '0, 1, 32'h3104, 32'h0000_00F2, 0, 0);
    step(1, 0, '0, '0, 0, '0, '0, 0, 0);
    idle(6, 1);

    // Randomised traffic over a small address pool so conflicts are frequent.
    dr_lvl = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      cr = ($urandom_range(0, 9) < 7);
      lv = ($urandom_range(0, 9) < 6);
      a  = 32'h1000 + 32'($urandom_range(0, 7) << 2);
      sc = ($urandom_range(0, 2) == 0) && (sbq.size() < DEPTH || (m_valid && m_write && cr));
      if ($urandom_range(0, 39) == 0) dr_lvl = ~dr_lvl;
      step(($urandom_range(0, 19) == 0), lv, a, TW'($urandom), sc,
           32'h1000 + 32'($urandom_range(0, 7) << 2), $urandom, dr_lvl, cr);
    end
    idle(20, 1);

    // Asynchronous reset with stores buffered discards them.
    for (int i = 0; i < 3; i++)
      step(0, 0, '0, '0, 1, 32'h5000 + 32'(4 * i), 32'hC000 + 32'(i), 0, 0);
    rst_n = 0;
    #2;
    check("midrst_sb_empty", sb_empty, 1);
    check("midrst_req_valid", req_valid, 0);
    sbq.delete(); txn_q.delete(); cyc_q.delete();
    m_valid = 0; m_write = 0; m_drain = 0; m_starve = 0;
    flush = 0; ld_valid = 0; st_commit = 0; drain_req = 0; cache_ready = 0;
    @(posedge clk); #1;
    rst_n = 1;
    step(0, 1, 32'h5000, 5'd4, 0, '0, '0, 0, 1);
    idle(3, 1);

    check("txn_residual", txn_q.size(), m_valid ? 1 : 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Owns the single data-cache request port and shares it between two requesters.
- Requester 1: speculative loads issued by the memory reservation station.
- Requester 2: committed stores released by the ROB, held in an internal FIFO store buffer.
- Enforces load/store address ordering, bounded load priority, and a drain mode; drives one registered request toward the d-cache.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, store data width.
- TAG_BITS, ROB_DEPTH_BITS, load ROB tag width.
- SB_DEPTH, 8, store-buffer entries; power of two, ≥2.
- STARVE_LIMIT, 4, max consecutive load grants while a store waits.

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  branch-mispredict flush
- ld_valid  in  1  load ready to issue
- ld_addr  in  ADDR_WIDTH  load address
- ld_tag  in  TAG_BITS  load ROB tag
- ld_grant  out  1  load accepted this cycle; requester pops
- st_commit  in  1  ROB commits a store
- st_addr  in  ADDR_WIDTH  committed store address
- st_data  in  DATA_WIDTH  committed store data
- sb_full  out  1  store buffer full; ROB must not commit a store
- sb_empty  out  1  store buffer empty
- drain_req  in  1  request full store drain, level
- drain_done  out  1  drain complete
- cache_ready  in  1  d-cache accepts the current request
- req_valid  out  1  request valid
- req_write  out  1  1 = store, 0 = load
- req_addr  out  ADDR_WIDTH  request address
- req_data  out  DATA_WIDTH  store data; 0 for loads
- req_tag  out  TAG_BITS  load tag; 0 for stores

Behaviour:
- Reset values: all outputs 0 except sb_empty = 1. Buffer pointers 0, starve counter 0, FSM in IDLE.
- Store buffer:
  - Circular FIFO; pointers are log2(SB_DEPTH)+1 bits, with the MSB used to tell full from empty.
  - Push on st_commit && !sb_full. A commit while full is a protocol error: assert it, entry is dropped.
  - Pop only when a store request is accepted by the cache.
  - Push and pop in the same cycle are both legal, including when full; occupancy is unchanged.
- Load conflict:
  - ld_block = 1 when ld_addr equals the address of any valid buffer entry, or of an in-flight store request.
  - Comparison is on the full address.
  - A blocked load is never granted.
- FSM states IDLE, BUSY, DRAIN:
  - IDLE:
    - Selection when no request is pending:
      - Store wins if sb_full, or starve count ≥ STARVE_LIMIT, or the load is absent or blocked.
      - Otherwise the load wins.
    - A winner is registered onto req_*; go to BUSY.
    - ld_grant pulses combinationally in the same cycle the load is registered.
    - If drain_req is high, go to DRAIN instead; loads are not granted.
  - BUSY:
    - req_* held stable until cache_ready.
    - On cache_ready, return to IDLE logic in the same cycle: a new winner may be registered immediately, giving one request per cycle back-to-back.
    - A store entry pops at acceptance, not at selection.
  - DRAIN:
    - Issues only stores.
    - drain_done = 1 while the buffer is empty and no store is in flight.
    - Leave DRAIN when drain_req deasserts.
- Starve counter:
  - Increments on a load grant while sb_empty = 0.
  - Clears on a store grant or when the buffer is empty.
  - Saturates at STARVE_LIMIT.
- Flush:
  - Drops a registered load request (req_valid → 0 next cycle) whether or not it has been accepted.
  - ld_grant is suppressed during flush.
  - Store buffer and in-flight stores are unaffected; committed stores are architectural.
- Asynchronous reset mid-operation discards all state, including buffered stores.
- Latency: request appears on req_* one cycle after grant.

Optional Feature:
- Macro: DCACHE_ARB_PERF_EN.
- Defined:
  - Adds 32-bit saturating outputs perf_ld_grants, perf_st_grants and perf_conflict_cycles.
  - perf_conflict_cycles counts cycles with ld_valid && ld_block.
  - All three reset to 0; none are cleared by flush.
- Undefined: these ports and counters are absent; no other behaviour changes.

Decomposition:
- Package mips_core_pkg gains:
  - typedef sb_entry_t {valid, addr, data}.
  - typedef enum arb_state_t {IDLE, BUSY, DRAIN}.
  - Constants SB_DEPTH_BITS and STARVE_LIMIT default.
- One sub-module, store_buffer_fifo:
  - Handles push, pop, full, empty.
  - Exposes a parallel address-compare output used for ld_block.

Test Plan:
- Reset, then a single load at 0x100, tag 3, with cache_ready = 1 → ld_grant in cycle 0; req_valid=1, write=0, addr=0x100, tag=3 in cycle 1.
- Commit a store to 0x200, then a load to 0x200 → load blocked until the store is accepted; load is granted the cycle after acceptance.
- Loads to non-conflicting addresses every cycle with 1 buffered store, STARVE_LIMIT=4 → exactly 4 loads granted, then the store, counter reset.
- Fill 8 stores with cache_ready = 0 → sb_full=1; commit and accept in the same cycle keep sb_full=1; request held stable while stalled.
- drain_req with 3 buffered stores and pending loads → 3 stores issued, no ld_grant, then drain_done=1.
- flush while a load request is pending and cache_ready = 0 → req_valid=0 next cycle; buffered stores are then issued unchanged.
